alu_exec_unit: RTL and testbench

Execute-stage block of the MIPS datapath. It decodes the main-control ALU opcode and the instruction funct field into an ALU operation and a jump-register flag. It computes the 32-bit ALU result and zero flag, and forms the branch target address from PC+4 and the sign-extended offset. All outputs are registered: one cycle of latency, synchronous reset.

---
 rtl/alu_exec_unit.sv | 134 +++++++++++++
 tb/tb_alu_exec_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - MIPS execute stage: ALU control decode, ALU, branch target
//
// Decodes ALU_Op/Funct into a 4-bit ALU operation and a jump-register flag,
// computes the 32-bit result and zero flag, and forms the branch target.
// Every output is registered (1-cycle latency, synchronous active-high reset).
//
// Ports:
//   Clock, Reset                 clock and synchronous active-high reset
//   ALU_Op[2:0], Funct[5:0]      operation class and R-type function field
//   Shamt[4:0]                   constant shift amount
//   Read_Data_1, ALU_B           operands A and B
//   PC_Plus4, Sign_Ext           branch target inputs
//   Alu_Result, Zero             registered result and result==0 flag
//   ALUctrl, JR_Signal           registered decoded operation and jr flag
//   Branch_Target                registered PC_Plus4 + (Sign_Ext << 2)

module alu_exec_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  ALU_Op,
  input  logic [5:0]  Funct,
  input  logic [4:0]  Shamt,
  input  logic [31:0] Read_Data_1,
  input  logic [31:0] ALU_B,
  input  logic [31:0] PC_Plus4,
  input  logic [31:0] Sign_Ext,
  output logic [31:0] Alu_Result,
  output logic        Zero,
  output logic [3:0]  ALUctrl,
  output logic        JR_Signal,
  output logic [31:0] Branch_Target
);

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SLL  = 4'b0011;
  localparam logic [3:0] CTRL_SRL  = 4'b0100;
  localparam logic [3:0] CTRL_SRA  = 4'b0101;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_XOR  = 4'b1000;
  localparam logic [3:0] CTRL_SLTU = 4'b1001;
  localparam logic [3:0] CTRL_LUI  = 4'b1010;
  localparam logic [3:0] CTRL_SLLV = 4'b1011;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_SRLV = 4'b1101;

  logic [3:0]  ctrl_next;
  logic        jr_next;
  logic [31:0] result_next;
  logic [31:0] target_next;

  // ALU control decode
  always_comb begin
    ctrl_next = CTRL_ADD;
    jr_next   = 1'b0;
    case (ALU_Op)
      3'b000: ctrl_next = CTRL_ADD;
      3'b001: ctrl_next = CTRL_SUB;
      3'b010: begin
        case (Funct)
          6'b100000, 6'b100001: ctrl_next = CTRL_ADD;
          6'b100010, 6'b100011: ctrl_next = CTRL_SUB;
          6'b100100: ctrl_next = CTRL_AND;
          6'b100101: ctrl_next = CTRL_OR;
          6'b100110: ctrl_next = CTRL_XOR;
          6'b100111: ctrl_next = CTRL_NOR;
          6'b101010: ctrl_next = CTRL_SLT;
          6'b101011: ctrl_next = CTRL_SLTU;
          6'b000000: ctrl_next = CTRL_SLL;
          6'b000010: ctrl_next = CTRL_SRL;
          6'b000011: ctrl_next = CTRL_SRA;
          6'b000100: ctrl_next = CTRL_SLLV;
          6'b000110: ctrl_next = CTRL_SRLV;
          6'b001000: begin
            // jr still runs an ADD so the datapath sees a benign result
            ctrl_next = CTRL_ADD;
            jr_next   = 1'b1;
          end
          default: ctrl_next = CTRL_ADD;
        endcase
      end
      3'b011: ctrl_next = CTRL_AND;
      3'b100: ctrl_next = CTRL_OR;
      3'b101: ctrl_next = CTRL_SLT;
      3'b110: ctrl_next = CTRL_LUI;
      3'b111: ctrl_next = CTRL_XOR;
      default: ctrl_next = CTRL_ADD;
    endcase
  end

  // ALU datapath
  always_comb begin
    result_next = 32'h0;
    case (ctrl_next)
      CTRL_AND:  result_next = Read_Data_1 & ALU_B;
      CTRL_OR:   result_next = Read_Data_1 | ALU_B;
      CTRL_ADD:  result_next = Read_Data_1 + ALU_B;
      CTRL_SLL:  result_next = ALU_B << Shamt;
      CTRL_SRL:  result_next = ALU_B >> Shamt;
      CTRL_SRA:  result_next = $signed(ALU_B) >>> Shamt;
      CTRL_SUB:  result_next = Read_Data_1 - ALU_B;
      CTRL_SLT:  result_next = {31'h0, $signed(Read_Data_1) < $signed(ALU_B)};
      CTRL_XOR:  result_next = Read_Data_1 ^ ALU_B;
      CTRL_SLTU: result_next = {31'h0, Read_Data_1 < ALU_B};
      CTRL_LUI:  result_next = {ALU_B[15:0], 16'h0000};
      // Variable shifts use only the low five bits of A
      CTRL_SLLV: result_next = ALU_B << Read_Data_1[4:0];
      CTRL_NOR:  result_next = ~(Read_Data_1 | ALU_B);
      CTRL_SRLV: result_next = ALU_B >> Read_Data_1[4:0];
      default:   result_next = 32'h0;
    endcase
  end

  assign target_next = PC_Plus4 + (Sign_Ext << 2);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Alu_Result    <= 32'h0;
      Zero          <= 1'b0;
      ALUctrl       <= 4'b0000;
      JR_Signal     <= 1'b0;
      Branch_Target <= 32'h0;
    end else begin
      Alu_Result    <= result_next;
      Zero          <= (result_next == 32'h0);
      ALUctrl       <= ctrl_next;
      JR_Signal     <= jr_next;
      Branch_Target <= target_next;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit

module tb_alu_exec_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [2:0]  ALU_Op;
  logic [5:0]  Funct;
  logic [4:0]  Shamt;
  logic [31:0] Read_Data_1;
  logic [31:0] ALU_B;
  logic [31:0] PC_Plus4;
  logic [31:0] Sign_Ext;
  logic [31:0] Alu_Result;
  logic        Zero;
  logic [3:0]  ALUctrl;
  logic        JR_Signal;
  logic [31:0] Branch_Target;

  int checks = 0;
  int errors = 0;

  alu_exec_unit dut (
    .Clock(Clock), .Reset(Reset), .ALU_Op(ALU_Op), .Funct(Funct), .Shamt(Shamt),
    .Read_Data_1(Read_Data_1), .ALU_B(ALU_B), .PC_Plus4(PC_Plus4), .Sign_Ext(Sign_Ext),
    .Alu_Result(Alu_Result), .Zero(Zero), .ALUctrl(ALUctrl), .JR_Signal(JR_Signal),
    .Branch_Target(Branch_Target)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one operation, clock it in, sample 1 time unit after the edge
  task automatic op(input logic rst, input logic [2:0] aop, input logic [5:0] fn,
                    input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
    Reset = rst; ALU_Op = aop; Funct = fn; Shamt = sh; Read_Data_1 = a; ALU_B = b;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] res, input logic z,
                         input logic [3:0] ctrl);
    chk({tag, "_result"}, Alu_Result, res);
    chk({tag, "_zero"}, {31'h0, Zero}, {31'h0, z});
    chk({tag, "_ctrl"}, {28'h0, ALUctrl}, {28'h0, ctrl});
  endtask

  initial begin
    PC_Plus4 = 32'h0040_0010;
    Sign_Ext = 32'h0000_0001;
    @(negedge Clock);

    // Reset held two cycles with non-zero operands
    op(1'b1, 3'b010, 6'b001000, 5'd3, 32'h5, 32'h7);
    op(1'b1, 3'b010, 6'b001000, 5'd3, 32'h5, 32'h7);
    chk_res("reset", 32'h0, 1'b0, 4'b0000);
    chk("reset_jr", {31'h0, JR_Signal}, 32'h0);
    chk("reset_target", Branch_Target, 32'h0);

    // First op after reset
    op(1'b0, 3'b000, 6'h0, 5'd0, 32'd5, 32'd7);
    chk_res("add_first", 32'd12, 1'b0, 4'b0010);
    chk("target_plus1", Branch_Target, 32'h0040_0014);

    op(1'b0, 3'b001, 6'h0, 5'd0, 32'h1234, 32'h1234);
    chk_res("sub_eq", 32'h0, 1'b1, 4'b0110);
    op(1'b0, 3'b001, 6'h0, 5'd0, 32'h1234, 32'h1235);
    chk_res("sub_neg", 32'hFFFF_FFFF, 1'b0, 4'b0110);

    // R-type sweep
    op(1'b0, 3'b010, 6'b100100, 5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk_res("r_and", 32'h00F0_00F0, 1'b0, 4'b0000);
    op(1'b0, 3'b010, 6'b100101, 5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk_res("r_or", 32'hFFF0_FFF0, 1'b0, 4'b0001);
    op(1'b0, 3'b010, 6'b100110, 5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk_res("r_xor", 32'hFF00_FF00, 1'b0, 4'b1000);
    op(1'b0, 3'b010, 6'b100111, 5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk_res("r_nor", 32'h000F_000F, 1'b0, 4'b1100);
    op(1'b0, 3'b010, 6'b000000, 5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk_res("r_sll", 32'hFF00_FF00, 1'b0, 4'b0011);
    op(1'b0, 3'b010, 6'b000010, 5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk_res("r_srl", 32'h00FF_00FF, 1'b0, 4'b0100);
    op(1'b0, 3'b010, 6'b000011, 5'd4, 32'hF0F0_F0F0, 32'h8000_0000);
    chk_res("r_sra", 32'hF800_0000, 1'b0, 4'b0101);
    op(1'b0, 3'b010, 6'b100011, 5'd0, 32'd10, 32'd3);
    chk_res("r_subu", 32'd7, 1'b0, 4'b0110);
    op(1'b0, 3'b010, 6'b000000, 5'd0, 32'h0, 32'h8765_4321);
    chk_res("sll_zero", 32'h8765_4321, 1'b0, 4'b0011);

    // Variable shifts use A[4:0] only
    op(1'b0, 3'b010, 6'b000100, 5'd7, 32'd32, 32'h0000_1234);
    chk_res("sllv_32", 32'h0000_1234, 1'b0, 4'b1011);
    op(1'b0, 3'b010, 6'b000100, 5'd0, 32'd8, 32'h0000_1234);
    chk_res("sllv_8", 32'h0012_3400, 1'b0, 4'b1011);
    op(1'b0, 3'b010, 6'b000110, 5'd0, 32'd36, 32'h0000_0080);
    chk_res("srlv_36", 32'h0000_0008, 1'b0, 4'b1101);

    // Compares, LUI, immediate ops
    op(1'b0, 3'b101, 6'h0, 5'd0, 32'hFFFF_FFFF, 32'd1);
    chk_res("slti", 32'd1, 1'b0, 4'b0111);
    op(1'b0, 3'b010, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1);
    chk_res("sltu", 32'd0, 1'b1, 4'b1001);
    op(1'b0, 3'b010, 6'b101010, 5'd0, 32'd1, 32'hFFFF_FFFF);
    chk_res("slt_r", 32'd0, 1'b1, 4'b0111);
    op(1'b0, 3'b110, 6'h0, 5'd0, 32'h0, 32'h0000_ABCD);
    chk_res("lui", 32'hABCD_0000, 1'b0, 4'b1010);
    op(1'b0, 3'b011, 6'h0, 5'd0, 32'hFF00_FF00, 32'h0000_0FF0);
    chk_res("andi", 32'h0000_0F00, 1'b0, 4'b0000);
    op(1'b0, 3'b100, 6'h0, 5'd0, 32'hFF00_0000, 32'h0000_00FF);
    chk_res("ori", 32'hFF00_00FF, 1'b0, 4'b0001);
    op(1'b0, 3'b111, 6'h0, 5'd0, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    chk_res("xori", 32'h5555_5555, 1'b0, 4'b1000);

    // Add boundaries
    op(1'b0, 3'b000, 6'h0, 5'd0, 32'h7FFF_FFFF, 32'd1);
    chk_res("add_ovf", 32'h8000_0000, 1'b0, 4'b0010);
    op(1'b0, 3'b000, 6'h0, 5'd0, 32'hFFFF_FFFF, 32'd1);
    chk_res("add_wrap", 32'h0, 1'b1, 4'b0010);

    // JR and unknown funct
    op(1'b0, 3'b010, 6'b001000, 5'd0, 32'd1, 32'd2);
    chk_res("jr", 32'd3, 1'b0, 4'b0010);
    chk("jr_flag", {31'h0, JR_Signal}, 32'd1);
    op(1'b0, 3'b000, 6'b001000, 5'd0, 32'd1, 32'd2);
    chk("jr_not_rtype", {31'h0, JR_Signal}, 32'd0);
    op(1'b0, 3'b010, 6'b111111, 5'd0, 32'd4, 32'd5);
    chk_res("funct_unknown", 32'd9, 1'b0, 4'b0010);
    chk("funct_unknown_jr", {31'h0, JR_Signal}, 32'd0);

    // Branch targets
    PC_Plus4 = 32'h0040_0010; Sign_Ext = 32'hFFFF_FFFE;
    op(1'b0, 3'b001, 6'h0, 5'd0, 32'd1, 32'd1);
    chk("target_neg", Branch_Target, 32'h0040_0008);
    Sign_Ext = 32'd3;
    op(1'b0, 3'b001, 6'h0, 5'd0, 32'd1, 32'd1);
    chk("target_pos", Branch_Target, 32'h0040_001C);

    // Reset mid-stream discards the sampled ADD
    op(1'b0, 3'b000, 6'h0, 5'd0, 32'd20, 32'd22);
    chk_res("add_pre_rst", 32'd42, 1'b0, 4'b0010);
    op(1'b1, 3'b000, 6'h0, 5'd0, 32'd20, 32'd22);
    chk_res("mid_reset", 32'h0, 1'b0, 4'b0000);
    chk("mid_reset_target", Branch_Target, 32'h0);
    op(1'b0, 3'b000, 6'h0, 5'd0, 32'd1, 32'd1);
    chk_res("post_reset", 32'd2, 1'b0, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
